intersection_ctrl: RTL and testbench

Sequences a two-approach intersection: north-south (NS) and east-west (EW) vehicle heads plus one pedestrian WALK signal. Each vehicle head presents the same one-hot red/yellow/green lamp interface as the existing single traffic_light block. Phase durations are parameters. A latched pedestrian request inserts an exclusive walk phase after the next all-red clearance.

---
 rtl/traffic_pkg.sv | 56 +++++
 rtl/phase_timer.sv | 30 +++
 rtl/intersection_ctrl.sv | 126 ++++++++++++
 tb/tb_intersection_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic signal blocks.
// Holds the 3-bit phase encodings, the safe fallback phase, the default
// phase durations shared with traffic_light, the lamp bundle type and
// helpers for lamp decode and duration clamping.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        AR_TO_EW  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        AR_TO_NS  = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    // Both approaches red: the place to land from any corrupted encoding.
    localparam state_t SAFE_STATE = AR_TO_NS;

    localparam int unsigned DEF_GREEN_TIME   = 11;
    localparam int unsigned DEF_YELLOW_TIME  = 4;
    localparam int unsigned DEF_ALL_RED_TIME = 2;
    localparam int unsigned DEF_PED_TIME     = 8;
    localparam int unsigned DEF_CNT_W        = 8;

    typedef struct packed {
        logic walk;
        logic ns_red;
        logic ns_yellow;
        logic ns_green;
        logic ew_red;
        logic ew_yellow;
        logic ew_green;
    } lamps_t;

    // Lamp pattern for a phase; unknown encodings show both approaches red.
    function automatic lamps_t lamp_decode(input state_t s);
        lamps_t l;
        l = '0;
        case (s)
            NS_GREEN:  begin l.ns_green  = 1'b1; l.ew_red = 1'b1; end
            NS_YELLOW: begin l.ns_yellow = 1'b1; l.ew_red = 1'b1; end
            EW_GREEN:  begin l.ew_green  = 1'b1; l.ns_red = 1'b1; end
            EW_YELLOW: begin l.ew_yellow = 1'b1; l.ns_red = 1'b1; end
            PED_WALK:  begin l.ns_red = 1'b1; l.ew_red = 1'b1; l.walk = 1'b1; end
            default:   begin l.ns_red = 1'b1; l.ew_red = 1'b1; end
        endcase
        return l;
    endfunction

    // A zero duration behaves as a one-cycle phase.
    function automatic int unsigned min1(input int unsigned t);
        return (t == 0) ? 1 : t;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with terminal-count flag.
// Ports: clk, rst (sync, active-low, loads RST_VAL), load/load_val
// (reload the count), done (count is zero). The count holds at zero.
module phase_timer import traffic_pkg::*; #(
    parameter int unsigned       CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] r_cnt;

    // Count register: reload takes priority over the decrement.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= RST_VAL;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign done = (r_cnt == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-approach intersection sequencer with an exclusive pedestrian phase.
// Ports: clk, rst (sync, active-low), ped_req (button, sampled every cycle),
// ped_ack (pulse on first walk cycle), ped_walk, ns_/ew_ red/yellow/green
// lamps (registered Moore decode), phase (current state encoding).
module intersection_ctrl import traffic_pkg::*; #(
    parameter int unsigned GREEN_TIME   = DEF_GREEN_TIME,
    parameter int unsigned YELLOW_TIME  = DEF_YELLOW_TIME,
    parameter int unsigned ALL_RED_TIME = DEF_ALL_RED_TIME,
    parameter int unsigned PED_TIME     = DEF_PED_TIME,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       ped_walk,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic [2:0] phase
);

    // Timer reload values: each phase is held exactly its duration.
    localparam logic [CNT_W-1:0] LD_GREEN   = CNT_W'(min1(GREEN_TIME) - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW  = CNT_W'(min1(YELLOW_TIME) - 1);
    localparam logic [CNT_W-1:0] LD_ALL_RED = CNT_W'(min1(ALL_RED_TIME) - 1);
    localparam logic [CNT_W-1:0] LD_PED     = CNT_W'(min1(PED_TIME) - 1);

    state_t           r_state;
    state_t           w_state_next;
    state_t           r_resume;
    logic             r_ped_pending;
    logic             r_ped_ack;
    lamps_t           r_lamps;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_done;
    logic             w_enter_ped;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (LD_GREEN)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .done     (w_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= NS_GREEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, timer reload and walk-entry detection.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = LD_GREEN;
        w_enter_ped  = 1'b0;

        case (r_state)
            NS_GREEN:  if (w_done) w_state_next = NS_YELLOW;
            NS_YELLOW: if (w_done) w_state_next = AR_TO_EW;
            AR_TO_EW:  if (w_done) w_state_next = r_ped_pending ? PED_WALK : EW_GREEN;
            EW_GREEN:  if (w_done) w_state_next = EW_YELLOW;
            EW_YELLOW: if (w_done) w_state_next = AR_TO_NS;
            AR_TO_NS:  if (w_done) w_state_next = r_ped_pending ? PED_WALK : NS_GREEN;
            PED_WALK:  if (w_done) w_state_next = r_resume;
            default:   w_state_next = SAFE_STATE;
        endcase

        // Any phase change (including recovery) restarts the timer.
        w_load = (w_state_next != r_state) || w_done;

        case (w_state_next)
            NS_GREEN, EW_GREEN:   w_load_val = LD_GREEN;
            NS_YELLOW, EW_YELLOW: w_load_val = LD_YELLOW;
            PED_WALK:             w_load_val = LD_PED;
            default:              w_load_val = LD_ALL_RED;
        endcase

        w_enter_ped = (w_state_next == PED_WALK) && (r_state != PED_WALK);
    end

    // Pedestrian latch, resume target, ack pulse and registered lamps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ped_pending <= 1'b0;
            r_resume      <= NS_GREEN;
            r_ped_ack     <= 1'b0;
            r_lamps       <= lamp_decode(NS_GREEN);
        end else begin
            // Entering walk clears the latch and absorbs a same-edge press.
            if (w_enter_ped) begin
                r_ped_pending <= 1'b0;
            end else if (ped_req && (r_state != PED_WALK)) begin
                r_ped_pending <= 1'b1;
            end
            if (w_enter_ped) begin
                r_resume <= (r_state == AR_TO_EW) ? EW_GREEN : NS_GREEN;
            end
            r_ped_ack <= w_enter_ped;
            r_lamps   <= lamp_decode(w_state_next);
        end
    end

    assign ped_ack   = r_ped_ack;
    assign ped_walk  = r_lamps.walk;
    assign ns_red    = r_lamps.ns_red;
    assign ns_yellow = r_lamps.ns_yellow;
    assign ns_green  = r_lamps.ns_green;
    assign ew_red    = r_lamps.ew_red;
    assign ew_yellow = r_lamps.ew_yellow;
    assign ew_green  = r_lamps.ew_green;
    assign phase     = r_state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Self-checking bench for intersection_ctrl: vector table, scoreboard
// against an elapsed-time reference model, corner sequences, random stream.
module tb_intersection_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ped_req;
    logic       ped_ack, ped_walk;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
    logic [2:0] phase;

    always #5 clk = ~clk;

    intersection_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ped_req   (ped_req),
        .ped_ack   (ped_ack),
        .ped_walk  (ped_walk),
        .ns_red    (ns_red),
        .ns_yellow (ns_yellow),
        .ns_green  (ns_green),
        .ew_red    (ew_red),
        .ew_yellow (ew_yellow),
        .ew_green  (ew_green),
        .phase     (phase)
    );

    typedef struct packed {
        logic [2:0] ph;
        logic       walk;
        logic       ack;
        logic       nr, ny, ng, er, ey, eg;
    } obs_t;

    typedef struct {
        int   n;
        bit   r;
        bit   p;
        logic [2:0] ph;
        bit   walk;
    } vec_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: state, cycles spent in it, pending latch, resume.
    int ms = 0, me = 1, mr = 0;
    bit mp = 0, mack = 0;

    function automatic int dur(input int s);
        case (s)
            0, 3:    return 11;
            1, 4:    return 4;
            6:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic obs_t expect_of(input int s, input bit ack);
        obs_t o;
        o = '0;
        o.ph  = 3'(s);
        o.ack = ack;
        case (s)
            0: begin o.ng = 1; o.er = 1; end
            1: begin o.ny = 1; o.er = 1; end
            3: begin o.eg = 1; o.nr = 1; end
            4: begin o.ey = 1; o.nr = 1; end
            6: begin o.nr = 1; o.er = 1; o.walk = 1; end
            default: begin o.nr = 1; o.er = 1; end
        endcase
        return o;
    endfunction

    task automatic model_step(input bit r, input bit p);
        int nxt;
        bit enter;
        if (!r) begin
            ms = 0; me = 1; mp = 0; mack = 0;
        end else begin
            enter = 0;
            if (me >= dur(ms)) begin
                case (ms)
                    0: nxt = 1;
                    1: nxt = 2;
                    2: nxt = mp ? 6 : 3;
                    3: nxt = 4;
                    4: nxt = 5;
                    5: nxt = mp ? 6 : 0;
                    default: nxt = mr;
                endcase
                if (nxt == 6) begin
                    enter = 1;
                    mr = (ms == 2) ? 3 : 0;
                end
                me = 1;
            end else begin
                nxt = ms;
                me++;
            end
            if (enter) mp = 0;
            else if (p && ms != 6) mp = 1;
            ms   = nxt;
            mack = enter;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o = {phase, ped_walk, ped_ack, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
        return o;
    endfunction

    // One clock: drive, predict, compare outputs and safety invariants.
    task automatic step(input bit r, input bit p);
        obs_t o, e;
        rst     = r;
        ped_req = p;
        model_step(r, p);
        exp_q.push_back(expect_of(ms, mack));
        @(posedge clk);
        #1;
        o = sample();
        e = exp_q.pop_front();
        check("scoreboard", 32'(o), 32'(e));
        check("ns one lamp", 32'($countones({ns_red, ns_yellow, ns_green})), 32'd1);
        check("ew one lamp", 32'($countones({ew_red, ew_yellow, ew_green})), 32'd1);
        check("one red", 32'(ns_red | ew_red), 32'd1);
        if (ped_walk) check("walk all red", 32'(ns_red & ew_red), 32'd1);
    endtask

    vec_t vt[16];

    initial begin
        int walks, acks, last_green;
        logic [2:0] prev;
        bit found;

        rst = 1'b0;
        ped_req = 1'b0;

        vt[0]  = '{2,  0, 0, 3'd0, 0};
        vt[1]  = '{10, 1, 0, 3'd0, 0};
        vt[2]  = '{1,  1, 0, 3'd1, 0};
        vt[3]  = '{4,  1, 0, 3'd2, 0};
        vt[4]  = '{2,  1, 0, 3'd3, 0};
        vt[5]  = '{11, 1, 0, 3'd4, 0};
        vt[6]  = '{4,  1, 0, 3'd5, 0};
        vt[7]  = '{2,  1, 0, 3'd0, 0};
        vt[8]  = '{1,  1, 1, 3'd0, 0};
        vt[9]  = '{16, 1, 0, 3'd6, 1};
        vt[10] = '{7,  1, 0, 3'd6, 1};
        vt[11] = '{1,  1, 0, 3'd3, 0};
        vt[12] = '{10, 1, 0, 3'd3, 0};
        vt[13] = '{5,  1, 0, 3'd5, 0};
        vt[14] = '{1,  1, 0, 3'd5, 0};
        vt[15] = '{1,  1, 0, 3'd0, 0};

        for (int v = 0; v < 16; v++) begin
            for (int k = 0; k < vt[v].n; k++) step(vt[v].r, vt[v].p);
            check($sformatf("vec%0d phase", v), 32'(phase), 32'(vt[v].ph));
            check($sformatf("vec%0d walk", v), 32'(ped_walk), 32'(vt[v].walk));
        end

        // Continuous request: walk after every all-red, greens alternate.
        walks = 0; acks = 0; last_green = 0; prev = phase;
        for (int k = 0; k < 100; k++) begin
            step(1, 1);
            if (phase == 3'd6 && prev != 3'd6) walks++;
            if (ped_ack) acks++;
            if ((phase == 3'd0 || phase == 3'd3) && phase != prev) begin
                check("green alternate", 32'(phase), (last_green == 0) ? 32'd3 : 32'd0);
                last_green = int'(phase);
            end
            prev = phase;
        end
        check("held walks", 32'(walks), 32'd4);
        check("held acks", 32'(acks), 32'd4);

        // Request only during walk must not schedule another walk.
        step(1, 1);
        for (int k = 0; k < 16; k++) step(1, 0);
        check("walk entered", 32'(phase), 32'd6);
        for (int k = 0; k < 8; k++) step(1, 1);
        check("resume ew", 32'(phase), 32'd3);
        walks = 0; prev = phase;
        for (int k = 0; k < 50; k++) begin
            step(1, 0);
            if (phase == 3'd6 && prev != 3'd6) walks++;
            prev = phase;
        end
        check("no extra walk", 32'(walks), 32'd0);

        // Reset pulse in the middle of EW yellow.
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (phase == 3'd4) begin
                found = 1;
                break;
            end
            step(1, 0);
        end
        check("find ew_yellow", 32'(found), 32'd1);
        step(1, 0);
        step(0, 0);
        check("rst phase", 32'(phase), 32'd0);
        check("rst ns_green", 32'(ns_green), 32'd1);
        check("rst ew_red", 32'(ew_red), 32'd1);
        check("rst walk", 32'(ped_walk), 32'd0);
        for (int k = 0; k < 10; k++) begin
            step(1, 0);
            check("post rst green", 32'(phase), 32'd0);
        end
        step(1, 0);
        check("post rst yellow", 32'(phase), 32'd1);

        // Random button stream with invariant checks every cycle.
        for (int k = 0; k < 500; k++) step(1, 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
